// File: rtl/fifo16x8_dp.sv
// Sixteen-entry first-word-fall-through FIFO wrapped around a dual-port RAM
// with an asynchronous read; status flags decode the registered occupancy count.
module fifo16x8_dp #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_present,
  output logic                  full,
  output logic                  half_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_HALF = {2'b01, {(DEPTH_LOG2-1){1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign data_present = (count != '0);
  assign full         = (count == CNT_FULL);
  assign half_full    = (count >= CNT_HALF);

  // A pop in the same edge frees a slot, so a full FIFO still takes a write.
  assign rd_en = read & data_present;
  assign wr_en = write & (~full | rd_en);

  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_ONE;
      end else if (rd_en && !wr_en) begin
        count <= count - CNT_ONE;
      end
      // A new error in the same cycle as clear_err wins.
      overflow  <= (overflow & ~clear_err) | (write & full & ~read);
      underflow <= (underflow & ~clear_err) | (read & ~data_present);
    end
  end

endmodule

// File: tb/tb_fifo16x8_dp.sv
// Self-checking bench for fifo16x8_dp: directed scenarios plus a random run,
// all compared against a queue-based reference model.
module tb_fifo16x8_dp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       write;
  logic       read;
  logic       clear_err;
  logic [7:0] data_out;
  logic       data_present;
  logic       full;
  logic       half_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_udf;

  fifo16x8_dp #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .write        (write),
    .read         (read),
    .clear_err    (clear_err),
    .data_out     (data_out),
    .data_present (data_present),
    .full         (full),
    .half_full    (half_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".count"},        32'(count),        32'(sz));
    check({tag, ".data_present"}, 32'(data_present), 32'(sz != 0));
    check({tag, ".full"},         32'(full),         32'(sz == 16));
    check({tag, ".half_full"},    32'(half_full),    32'(sz >= 8));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
    if (sz != 0) begin
      check({tag, ".data_out"}, 32'(data_out), 32'(mq[0]));
    end
  endtask

  // One clock of strobes; the model is advanced from the FIFO rules, not the RTL.
  task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] d,
                                input logic clr, input string tag);
    int  sz;
    logic pop;
    logic push;
    logic new_ovf;
    logic new_udf;
    data_in   = d;
    write     = w;
    read      = r;
    clear_err = clr;
    sz      = mq.size();
    pop     = r && (sz > 0);
    push    = w && ((sz < 16) || pop);
    new_ovf = w && (sz == 16) && !r;
    new_udf = r && (sz == 0);
    if (pop) begin
      check({tag, ".pop_data"}, 32'(data_out), 32'(mq[0]));
    end
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    m_ovf = (m_ovf && !clr) || new_ovf;
    m_udf = (m_udf && !clr) || new_udf;
    #1;
    write     = 1'b0;
    read      = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    write     = 1'b0;
    read      = 1'b0;
    clear_err = 1'b0;
    data_in   = 8'h00;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    #12;
    check_output("reset");
    reset = 1'b0;

    // Three writes, then three reads in order
    apply_stimulus(1, 0, 8'h11, 0, "w1");
    apply_stimulus(1, 0, 8'h22, 0, "w2");
    apply_stimulus(1, 0, 8'h33, 0, "w3");
    check_output("three_written");
    check("first_out", 32'(data_out), 32'h11);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 8'h00, 0, "r3");
    check_output("three_drained");

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1, 0, 8'(i), 0, "fill");
      if (i == 7) check("half_after_8", 32'(half_full), 32'h1);
      check_output("fill");
    end
    check("full_after_16", 32'(full), 32'h1);
    apply_stimulus(1, 0, 8'hFF, 0, "w17");
    check_output("overflow");
    check("overflow_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check("drain_value", 32'(data_out), 32'(i));
      apply_stimulus(0, 1, 8'h00, 0, "drain");
    end
    check_output("drained");
    apply_stimulus(0, 0, 8'h00, 1, "clr_ovf");
    check_output("ovf_cleared");

    // Simultaneous write and read while full
    for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 8'(i), 0, "refill");
    check("popped_full", 32'(data_out), 32'h00);
    apply_stimulus(1, 1, 8'hAA, 0, "wr_rd_full");
    check_output("wr_rd_full");
    check("next_after_pop", 32'(data_out), 32'h01);
    for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 8'h00, 0, "drain2");
    check("last_is_aa", 32'(data_out), 32'hAA);
    apply_stimulus(0, 1, 8'h00, 0, "drain2");
    check_output("drained2");

    // Underflow and clear
    apply_stimulus(0, 1, 8'h00, 0, "udf");
    check_output("underflow");
    check("underflow_set", 32'(underflow), 32'h1);
    apply_stimulus(0, 0, 8'h00, 1, "clr_udf");
    check_output("udf_cleared");
    // Read on empty with write: write lands, underflow sets
    apply_stimulus(1, 1, 8'h77, 0, "wr_rd_empty");
    check_output("wr_rd_empty");
    // Clear and new error in the same cycle keeps the flag
    apply_stimulus(0, 1, 8'h00, 0, "pop77");
    apply_stimulus(0, 1, 8'h00, 1, "clr_and_udf");
    check_output("clr_and_udf");
    apply_stimulus(0, 0, 8'h00, 1, "clr2");

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, 0, 8'h40 + 8'(i), 0, "wrap_w");
      check_output("wrap_w");
      apply_stimulus(0, 1, 8'h00, 0, "wrap_r");
      check_output("wrap_r");
    end

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 8'hC0 + 8'(i), 0, "load5");
    #3;
    reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_output("async_reset");
    write   = 1'b1;
    data_in = 8'h99;
    @(posedge clk);
    #1;
    write = 1'b0;
    check_output("strobe_in_reset");
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1, 0, 8'h5A, 0, "post_reset");
    check_output("post_reset");
    check("post_reset_data", 32'(data_out), 32'h5A);

    // Random traffic with write/read bias alternating to visit full and empty
    for (int i = 0; i < 600; i++) begin
      logic w;
      logic r;
      logic clr;
      if (((i / 60) % 2) == 0) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      clr = ($urandom_range(0, 15) == 0);
      apply_stimulus(w, r, 8'($urandom), clr, "rand");
      check_output("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
